// File: rtl/cpu_mem_xfer_if.sv
// Bundle of CPU request/response, RAM port and register-file port signals
// for the cpu_mem_xfer block-transfer engine.
interface cpu_mem_xfer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 16
) ();
  localparam int unsigned IDX_W = $clog2(NREGS);

  // CPU side
  logic              start;
  logic [1:0]        op;
  logic [ADDR_W-1:0] base_addr;
  logic [IDX_W-1:0]  last_reg;
  logic [DATA_W-1:0] bcd_value;
  logic              busy;
  logic              done;
  logic              err;
  logic              i_we;
  logic [ADDR_W-1:0] i_new;
  // RAM side
  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;
  // Register-file side
  logic [IDX_W-1:0]  reg_idx;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_we;
  logic [DATA_W-1:0] reg_wdata;

  modport master (
    output start, op, base_addr, last_reg, bcd_value, ram_out, reg_rdata,
    input  busy, done, err, i_we, i_new, ram_en, ram_wr, ram_addr, ram_in,
           reg_idx, reg_we, reg_wdata
  );

  modport slave (
    input  start, op, base_addr, last_reg, bcd_value, ram_out, reg_rdata,
    output busy, done, err, i_we, i_new, ram_en, ram_wr, ram_addr, ram_in,
           reg_idx, reg_we, reg_wdata
  );
endinterface

// File: rtl/cpu_mem_xfer.sv
// Block-transfer engine for Fx55 (store regs), Fx65 (load regs) and Fx33 (BCD):
// moves one byte per cycle between the register file and RAM.
module cpu_mem_xfer #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned I_INCREMENT = 0
) (
  input logic           clk,
  input logic           reset,
  cpu_mem_xfer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned TAG_N = RD_LATENCY + 1;

  typedef enum logic [2:0] {IDLE, STORE, LOAD, DRAIN, BCD, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  lim_q, lim_d;
  logic [7:0]        bcd_q, bcd_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic              busy_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              i_we_q, i_we_d;
  logic [ADDR_W-1:0] i_new_q, i_new_d;
  logic [ADDR_W-1:0] i_upd_c;
  logic              issue_d;
  logic [IDX_W-1:0]  issue_idx_d;
  logic [IDX_W-1:0]  reg_idx_c;
  logic              pending_c;
  logic              tag_v_q   [TAG_N];
  logic [IDX_W-1:0]  tag_idx_q [TAG_N];

  // Decimal digit sel (0 hundreds, 1 tens, 2 ones) of an 8-bit value
  function automatic logic [DATA_W-1:0] bcd_digit(input logic [7:0] v, input logic [1:0] sel);
    logic [7:0] d;
    case (sel)
      2'd0:    d = v / 8'd100;
      2'd1:    d = (v / 8'd10) % 8'd10;
      default: d = v % 8'd10;
    endcase
    return DATA_W'(d);
  endfunction

  // Loads still in flight before the write-back stage
  always_comb begin
    pending_c = 1'b0;
    for (int i = 0; i < int'(RD_LATENCY); i++) pending_c = pending_c | tag_v_q[i];
  end

  // lim_q holds N, so mode 2 (CHIP-48) lands one short of mode 1
  assign i_upd_c = base_q + ADDR_W'(lim_q) - ((I_INCREMENT == 2) ? ADDR_W'(1) : ADDR_W'(0));

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    bcd_d       = bcd_q;
    ram_en_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_in_d    = ram_in_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    i_we_d      = 1'b0;
    i_new_d     = i_new_q;
    issue_d     = 1'b0;
    issue_idx_d = '0;
    reg_idx_c   = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d     = bus.base_addr;
          bcd_d      = bus.bcd_value[7:0];
          cnt_d      = CNT_W'(1);
          lim_d      = CNT_W'(bus.last_reg) + CNT_W'(1);
          ram_addr_d = bus.base_addr;
          case (bus.op)
            2'd0: begin
              state_d  = STORE;
              ram_en_d = 1'b1;
              ram_wr_d = 1'b1;
              ram_in_d = bus.reg_rdata;
            end
            2'd1: begin
              state_d  = LOAD;
              ram_en_d = 1'b1;
              issue_d  = 1'b1;
            end
            2'd2: begin
              state_d  = BCD;
              lim_d    = CNT_W'(3);
              ram_en_d = 1'b1;
              ram_wr_d = 1'b1;
              ram_in_d = bcd_digit(bus.bcd_value[7:0], 2'd0);
            end
            default: begin
              state_d = FIN;
              done_d  = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end

      STORE, BCD: begin
        if (cnt_q == lim_q) begin
          state_d = FIN;
          done_d  = 1'b1;
          if (state_q == STORE && I_INCREMENT != 0) begin
            i_we_d  = 1'b1;
            i_new_d = i_upd_c;
          end
        end else begin
          ram_en_d   = 1'b1;
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + ADDR_W'(cnt_q);
          cnt_d      = cnt_q + CNT_W'(1);
          if (state_q == STORE) begin
            reg_idx_c = IDX_W'(cnt_q);
            ram_in_d  = bus.reg_rdata;
          end else begin
            ram_in_d  = bcd_digit(bcd_q, cnt_q[1:0]);
          end
        end
      end

      LOAD: begin
        if (cnt_q == lim_q) begin
          state_d = DRAIN;
        end else begin
          ram_en_d    = 1'b1;
          ram_addr_d  = base_q + ADDR_W'(cnt_q);
          issue_d     = 1'b1;
          issue_idx_d = IDX_W'(cnt_q);
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        if (!pending_c) begin
          state_d = FIN;
          done_d  = 1'b1;
          if (I_INCREMENT != 0) begin
            i_we_d  = 1'b1;
            i_new_d = i_upd_c;
          end
        end
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Load write-back owns the register index when a tag reaches the end
    if (tag_v_q[RD_LATENCY]) reg_idx_c = tag_idx_q[RD_LATENCY];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      lim_q      <= '0;
      bcd_q      <= '0;
      ram_en_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_in_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      i_we_q     <= 1'b0;
      i_new_q    <= '0;
      for (int i = 0; i < int'(TAG_N); i++) begin
        tag_v_q[i]   <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      lim_q      <= lim_d;
      bcd_q      <= bcd_d;
      ram_en_q   <= ram_en_d;
      ram_wr_q   <= ram_wr_d;
      ram_addr_q <= ram_addr_d;
      ram_in_q   <= ram_in_d;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      err_q      <= err_d;
      i_we_q     <= i_we_d;
      i_new_q    <= i_new_d;
      tag_v_q[0]   <= issue_d;
      tag_idx_q[0] <= issue_idx_d;
      for (int i = 1; i < int'(TAG_N); i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.i_we      = i_we_q;
  assign bus.i_new     = i_new_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_in    = ram_in_q;
  assign bus.reg_idx   = reg_idx_c;
  assign bus.reg_we    = tag_v_q[RD_LATENCY];
  assign bus.reg_wdata = tag_v_q[RD_LATENCY] ? bus.ram_out : '0;
endmodule

// File: tb/tb_cpu_mem_xfer.sv
// Directed bench for cpu_mem_xfer: RAM and register-file models, a vector table
// of transfers with hand-computed cycle expectations, plus reset/data sequences.
module tb_cpu_mem_xfer;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_mem_xfer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) bus ();

  cpu_mem_xfer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS),
    .RD_LATENCY(2), .I_INCREMENT(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // RAM model: registered address, data back two cycles later
  logic [7:0]  mem [4096];
  logic [7:0]  rd1;
  logic        pm_en;
  logic [11:0] pm_a;
  logic [7:0]  pm_d;
  always @(posedge clk) begin
    if (pm_en) mem[pm_a] <= pm_d;
    else if (bus.ram_en && bus.ram_wr) mem[bus.ram_addr] <= bus.ram_in;
    rd1 <= mem[bus.ram_addr];
    bus.ram_out <= rd1;
  end

  // Register-file model: combinational read, clocked write
  logic [7:0] regs [16];
  logic       pr_en;
  logic [3:0] pr_i;
  logic [7:0] pr_d;
  always @(posedge clk) begin
    if (pr_en) regs[pr_i] <= pr_d;
    else if (bus.reg_we) regs[bus.reg_idx] <= bus.reg_wdata;
  end
  assign bus.reg_rdata = regs[bus.reg_idx];

  typedef struct {
    logic [1:0]  op;
    logic [11:0] base;
    logic [3:0]  last;
    logic [7:0]  bcd;
    bit          repulse;
    int          wr_f, wr_l, rd_f, rd_l, we_f, we_l, done_c;
    bit          err, iwe;
    logic [11:0] inew;
  } xfer_t;

  typedef struct {
    int          wr_f, wr_l, rd_f, rd_l, we_f, we_l, done_c, busy_n;
    logic        err, iwe;
    logic [11:0] inew;
  } obs_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic poke_mem(input logic [11:0] a, input logic [7:0] d);
    pm_en = 1'b1; pm_a = a; pm_d = d;
    @(negedge clk);
    pm_en = 1'b0;
  endtask

  task automatic poke_reg(input logic [3:0] i, input logic [7:0] d);
    pr_en = 1'b1; pr_i = i; pr_d = d;
    @(negedge clk);
    pr_en = 1'b0;
  endtask

  // Issue one transfer; cycle 1 is the first cycle after the accept edge
  task automatic run(input string nm, input xfer_t t, output obs_t o);
    o = '{default: 0};
    @(negedge clk);
    chk({nm, " idle_before"}, 32'(bus.busy), 32'd0);
    bus.start = 1'b1; bus.op = t.op; bus.base_addr = t.base;
    bus.last_reg = t.last; bus.bcd_value = t.bcd;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'd3; bus.base_addr = 12'hABC;
    bus.last_reg = 4'd9; bus.bcd_value = 8'd99;
    for (int c = 1; c <= 60; c++) begin
      if (bus.busy) o.busy_n++;
      if (bus.ram_en && bus.ram_wr) begin if (o.wr_f == 0) o.wr_f = c; o.wr_l = c; end
      if (bus.ram_en && !bus.ram_wr) begin if (o.rd_f == 0) o.rd_f = c; o.rd_l = c; end
      if (bus.reg_we) begin if (o.we_f == 0) o.we_f = c; o.we_l = c; end
      if (bus.done) begin
        o.done_c = c; o.err = bus.err; o.iwe = bus.i_we; o.inew = bus.i_new;
        break;
      end
      if (t.repulse && c == 2) begin
        bus.start = 1'b1; bus.op = 2'd2; bus.base_addr = 12'h700; bus.bcd_value = 8'd123;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_obs(input string nm, input xfer_t t, input obs_t o);
    chk({nm, " done_cycle"}, 32'(o.done_c), 32'(t.done_c));
    chk({nm, " busy_cycles"}, 32'(o.busy_n), 32'(t.done_c));
    chk({nm, " wr_first"}, 32'(o.wr_f), 32'(t.wr_f));
    chk({nm, " wr_last"}, 32'(o.wr_l), 32'(t.wr_l));
    chk({nm, " rd_first"}, 32'(o.rd_f), 32'(t.rd_f));
    chk({nm, " rd_last"}, 32'(o.rd_l), 32'(t.rd_l));
    chk({nm, " we_first"}, 32'(o.we_f), 32'(t.we_f));
    chk({nm, " we_last"}, 32'(o.we_l), 32'(t.we_l));
    chk({nm, " err"}, 32'(o.err), 32'(t.err));
    chk({nm, " i_we"}, 32'(o.iwe), 32'(t.iwe));
    if (t.iwe) chk({nm, " i_new"}, 32'(o.inew), 32'(t.inew));
  endtask

  xfer_t tv [8];
  xfer_t post;
  obs_t  ob;
  bit    seen_done, seen_we, seen_en;

  initial begin
    //            op    base     last  bcd    rp  wr    rd     we    done err iwe inew
    tv[0] = '{2'd0, 12'h300, 4'd3,  8'd0,   0, 1, 4,  0, 0,  0, 0,  5,  0, 1, 12'h304};
    tv[1] = '{2'd0, 12'hFFE, 4'd2,  8'd0,   0, 1, 3,  0, 0,  0, 0,  4,  0, 1, 12'h001};
    tv[2] = '{2'd0, 12'h360, 4'd5,  8'd0,   1, 1, 6,  0, 0,  0, 0,  7,  0, 1, 12'h366};
    tv[3] = '{2'd2, 12'h200, 4'd7,  8'd254, 0, 1, 3,  0, 0,  0, 0,  4,  0, 0, 12'h000};
    tv[4] = '{2'd2, 12'h210, 4'd7,  8'd0,   0, 1, 3,  0, 0,  0, 0,  4,  0, 0, 12'h000};
    tv[5] = '{2'd3, 12'h500, 4'd4,  8'd0,   0, 0, 0,  0, 0,  0, 0,  1,  1, 0, 12'h000};
    tv[6] = '{2'd1, 12'h400, 4'd15, 8'd0,   0, 0, 0,  1, 16, 3, 18, 19, 0, 1, 12'h410};
    tv[7] = '{2'd1, 12'h3F0, 4'd0,  8'd0,   0, 0, 0,  1, 1,  3, 3,  4,  0, 1, 12'h3F1};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'd0; bus.base_addr = '0; bus.last_reg = '0; bus.bcd_value = '0;
    pm_en = 1'b0; pm_a = '0; pm_d = '0;
    pr_en = 1'b0; pr_i = '0; pr_d = '0;
    repeat (3) @(negedge clk);

    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst err", 32'(bus.err), 32'd0);
    chk("rst i_we", 32'(bus.i_we), 32'd0);
    chk("rst i_new", 32'(bus.i_new), 32'd0);
    chk("rst ram_en", 32'(bus.ram_en), 32'd0);
    chk("rst ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst ram_in", 32'(bus.ram_in), 32'd0);
    chk("rst reg_we", 32'(bus.reg_we), 32'd0);

    for (int k = 0; k < 6; k++) poke_reg(4'(k), 8'(11 * (k + 1)));
    for (int k = 0; k < 16; k++) poke_mem(12'h400 + 12'(k), 8'(k));
    poke_mem(12'h3F0, 8'h99);
    poke_mem(12'h700, 8'hEE);
    for (int k = 0; k < 3; k++) begin
      poke_mem(12'h200 + 12'(k), 8'hFF);
      poke_mem(12'h210 + 12'(k), 8'hFF);
    end
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run($sformatf("v%0d", i), tv[i], ob);
      check_obs($sformatf("v%0d", i), tv[i], ob);
    end

    // Reset in cycle 2 of a load abandons it silently
    poke_reg(4'd0, 8'h99);
    bus.start = 1'b1; bus.op = 2'd1; bus.base_addr = 12'h400; bus.last_reg = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid reg_we", 32'(bus.reg_we), 32'd0);
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    chk("rstmid ram_en", 32'(bus.ram_en), 32'd0);
    reset = 1'b0;
    seen_done = 0; seen_we = 0; seen_en = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen_done = 1;
      if (bus.reg_we) seen_we = 1;
      if (bus.ram_en) seen_en = 1;
    end
    chk("rstmid no_done", 32'(seen_done), 32'd0);
    chk("rstmid no_reg_we", 32'(seen_we), 32'd0);
    chk("rstmid no_ram_en", 32'(seen_en), 32'd0);
    chk("rstmid v0_kept", 32'(regs[0]), 32'h99);

    post = '{2'd0, 12'h380, 4'd1, 8'd0, 0, 1, 2, 0, 0, 0, 0, 3, 0, 1, 12'h382};
    run("post_rst", post, ob);
    check_obs("post_rst", post, ob);

    chk("mem 300", 32'(mem[12'h300]), 32'd11);
    chk("mem 301", 32'(mem[12'h301]), 32'd22);
    chk("mem 302", 32'(mem[12'h302]), 32'd33);
    chk("mem 303", 32'(mem[12'h303]), 32'd44);
    chk("mem FFE", 32'(mem[12'hFFE]), 32'd11);
    chk("mem FFF", 32'(mem[12'hFFF]), 32'd22);
    chk("mem 000", 32'(mem[12'h000]), 32'd33);
    for (int k = 0; k < 6; k++)
      chk($sformatf("mem 36%0d", k), 32'(mem[12'h360 + 12'(k)]), 32'(11 * (k + 1)));
    chk("mem 700 untouched", 32'(mem[12'h700]), 32'hEE);
    chk("mem 200", 32'(mem[12'h200]), 32'd2);
    chk("mem 201", 32'(mem[12'h201]), 32'd5);
    chk("mem 202", 32'(mem[12'h202]), 32'd4);
    chk("mem 210", 32'(mem[12'h210]), 32'd0);
    chk("mem 211", 32'(mem[12'h211]), 32'd0);
    chk("mem 212", 32'(mem[12'h212]), 32'd0);
    for (int k = 1; k < 16; k++)
      chk($sformatf("reg V%0d", k), 32'(regs[k]), 32'(k));
    chk("mem 380", 32'(mem[12'h380]), 32'h99);
    chk("mem 381", 32'(mem[12'h381]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
